// File: rtl/jt12_wr_pkg.sv
// jt12_wr_pkg: shared types and constants for the YM2612 write scheduler
package jt12_wr_pkg;
    localparam int ENTRY_W = 10;
    localparam logic HOST_A = 1'b0;
    localparam logic HOST_B = 1'b1;
    typedef enum logic [1:0] {IDLE, GAP, WAIT} drain_t;
endpackage

// File: rtl/jt12_wr_fifo.sv
// jt12_wr_fifo: register FIFO holding {addr, din} entries for the write scheduler
module jt12_wr_fifo import jt12_wr_pkg::*; #(
    parameter int DEPTH = 8,
    parameter int W     = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = level == (AW+1)'(DEPTH);
    assign empty   = level == '0;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk)
        if (do_push && !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/jt12_wr_sched.sv
// jt12_wr_sched: arbitrates two hosts' YM2612 writes into a FIFO and replays them
// to jt12_syn, keeping each address/data pair from one host together.
module jt12_wr_sched import jt12_wr_pkg::*; #(
    parameter int DEPTH   = 8,
    parameter int MIN_GAP = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     a_req,
    input  logic [1:0]               a_addr,
    input  logic [7:0]               a_din,
    output logic                     a_ack,
    input  logic                     b_req,
    input  logic [1:0]               b_addr,
    input  logic [7:0]               b_din,
    output logic                     b_ack,
    input  logic                     syn_busy,
    output logic                     syn_write,
    output logic [1:0]               syn_addr,
    output logic [7:0]               syn_din,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int CW = $clog2(MIN_GAP + 1);
    drain_t               state, nxt_state;
    logic [CW-1:0]        cnt, nxt_cnt;
    logic                 lock_v, lock_own, rr;
    logic                 elig_a, elig_b, gnt_a, gnt_b, push, issue;
    logic [1:0]           push_addr;
    logic [7:0]           push_din;
    logic [ENTRY_W-1:0]   head;

    // a host being acked this cycle still shows its old request, so it sits out
    assign elig_a    = a_req && !a_ack && (!lock_v || lock_own == HOST_A);
    assign elig_b    = b_req && !b_ack && (!lock_v || lock_own == HOST_B);
    assign gnt_a     = !full && !flush && elig_a && (!elig_b || rr == HOST_A);
    assign gnt_b     = !full && !flush && elig_b && (!elig_a || rr == HOST_B);
    assign push      = gnt_a || gnt_b;
    assign push_addr = gnt_b ? b_addr : a_addr;
    assign push_din  = gnt_b ? b_din : a_din;

    jt12_wr_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (issue),
        .din   ({push_addr, push_din}),
        .dout  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            lock_v   <= 1'b0;
            lock_own <= HOST_A;
            rr       <= HOST_A;
        end else begin
            a_ack <= gnt_a;
            b_ack <= gnt_b;
            if (elig_a && elig_b && push) rr <= gnt_a ? HOST_B : HOST_A;
            if (flush) lock_v <= 1'b0;
            else if (push) begin
                lock_v   <= !push_addr[0];
                lock_own <= gnt_b ? HOST_B : HOST_A;
            end
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        issue     = 1'b0;
        if (flush) nxt_state = IDLE;
        else begin
            unique case (state)
                IDLE: if (!empty && !syn_busy) begin
                    issue     = 1'b1;
                    nxt_state = GAP;
                    nxt_cnt   = '0;
                end
                GAP: begin
                    nxt_cnt = cnt + 1'b1;
                    if (cnt == CW'(MIN_GAP - 1)) nxt_state = WAIT;
                end
                WAIT: if (!syn_busy) nxt_state = IDLE;
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            syn_write <= 1'b0;
            syn_addr  <= '0;
            syn_din   <= '0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            syn_write <= issue;
            if (issue) {syn_addr, syn_din} <= head;
        end
    end
endmodule

// File: tb/tb_jt12_wr_sched.sv
// tb_jt12_wr_sched: scoreboard bench for the two-host YM2612 write scheduler
module tb_jt12_wr_sched;
    localparam int DEPTH   = 8;
    localparam int MIN_GAP = 2;

    logic       clk, rst_n, flush;
    logic       a_req, b_req, a_ack, b_ack;
    logic [1:0] a_addr, b_addr, syn_addr;
    logic [7:0] a_din, b_din, syn_din;
    logic       syn_busy, syn_write, full, empty;
    logic [3:0] level;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    logic [9:0] exp_q[$];
    bit         ack_log[$];

    jt12_wr_sched #(.DEPTH(DEPTH), .MIN_GAP(MIN_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .a_req(a_req), .a_addr(a_addr), .a_din(a_din), .a_ack(a_ack),
        .b_req(b_req), .b_addr(b_addr), .b_din(b_din), .b_ack(b_ack),
        .syn_busy(syn_busy), .syn_write(syn_write), .syn_addr(syn_addr), .syn_din(syn_din),
        .level(level), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pops the scoreboard on every strobe and checks issue spacing
    task automatic monitor();
        int cyc = 0;
        int last = -100;
        logic [9:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && syn_write) begin
                wr_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got=%h expected=none", {syn_addr, syn_din});
                end else begin
                    e = exp_q.pop_front();
                    if ({syn_addr, syn_din} !== e) begin
                        errors++;
                        $display("FAIL write_data got=%h expected=%h", {syn_addr, syn_din}, e);
                    end
                end
                checks++;
                if (cyc - last < MIN_GAP + 2) begin
                    errors++;
                    $display("FAIL write_gap got=%0d expected>=%0d", cyc - last, MIN_GAP + 2);
                end
                last = cyc;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; flush = 1'b0; syn_busy = 1'b0;
        a_req = 1'b0; a_addr = '0; a_din = '0;
        b_req = 1'b0; b_addr = '0; b_din = '0;
        exp_q.delete();
        ack_log.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit h, input logic [1:0] ad, input logic [7:0] d, input bit rel);
        int n = 0;
        bit got = 0;
        if (h) begin b_req = 1'b1; b_addr = ad; b_din = d; end
        else begin a_req = 1'b1; a_addr = ad; a_din = d; end
        while (!got && n < 50) begin
            @(posedge clk);
            #1;
            n++;
            got = h ? b_ack : a_ack;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout host=%0d got=0 expected=1", h);
        end else ack_log.push_back(h);
        if (rel) begin
            if (h) b_req = 1'b0;
            else a_req = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got=%0d left expected=0", exp_q.size());
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 8;
        if (syn_write !== 1'b0) begin errors++; $display("FAIL rst_syn_write got=%b expected=0", syn_write); end
        if (syn_addr !== 2'd0) begin errors++; $display("FAIL rst_syn_addr got=%h expected=0", syn_addr); end
        if (syn_din !== 8'd0) begin errors++; $display("FAIL rst_syn_din got=%h expected=0", syn_din); end
        if (a_ack !== 1'b0) begin errors++; $display("FAIL rst_a_ack got=%b expected=0", a_ack); end
        if (b_ack !== 1'b0) begin errors++; $display("FAIL rst_b_ack got=%b expected=0", b_ack); end
        if (level !== 4'd0) begin errors++; $display("FAIL rst_level got=%0d expected=0", level); end
        if (full !== 1'b0) begin errors++; $display("FAIL rst_full got=%b expected=0", full); end
        if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b expected=1", empty); end
    endtask

    task automatic test_single();
        apply_reset();
        exp_q.push_back({2'b00, 8'h28});
        exp_q.push_back({2'b01, 8'hF0});
        send(0, 2'b00, 8'h28, 0);
        send(0, 2'b01, 8'hF0, 1);
        wait_drain();
    endtask

    task automatic test_lock();
        bit exp_ack[3] = '{0, 0, 1};
        apply_reset();
        exp_q.push_back({2'b00, 8'h2A});
        exp_q.push_back({2'b01, 8'h80});
        exp_q.push_back({2'b11, 8'h55});
        fork
            begin send(0, 2'b00, 8'h2A, 0); send(0, 2'b01, 8'h80, 1); end
            send(1, 2'b11, 8'h55, 1);
        join
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= ack_log.size() || ack_log[i] !== exp_ack[i]) begin
                errors++;
                $display("FAIL lock_ack_order idx=%0d got=%0d expected=%0d", i,
                         i < ack_log.size() ? int'(ack_log[i]) : -1, exp_ack[i]);
            end
        end
        wait_drain();
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({2'b01, 8'(8'hA0 + i)});
            exp_q.push_back({2'b11, 8'(8'hB0 + i)});
        end
        fork
            for (int i = 0; i < 4; i++) send(0, 2'b01, 8'(8'hA0 + i), i == 3);
            for (int j = 0; j < 4; j++) send(1, 2'b11, 8'(8'hB0 + j), j == 3);
        join
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (k >= ack_log.size() || ack_log[k] !== bit'(k % 2)) begin
                errors++;
                $display("FAIL rr_ack_order idx=%0d got=%0d expected=%0d", k,
                         k < ack_log.size() ? int'(ack_log[k]) : -1, k % 2);
            end
        end
        wait_drain();
    endtask

    task automatic test_full();
        int w0;
        apply_reset();
        syn_busy = 1'b1;
        w0 = wr_count;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back({2'b01, 8'(8'h10 + i)});
            send(0, 2'b01, 8'(8'h10 + i), 1);
        end
        checks += 2;
        if (level !== 4'd8) begin errors++; $display("FAIL full_level got=%0d expected=8", level); end
        if (full !== 1'b1) begin errors++; $display("FAIL full_flag got=%b expected=1", full); end
        exp_q.push_back({2'b01, 8'h99});
        a_req = 1'b1; a_addr = 2'b01; a_din = 8'h99;
        repeat (6) begin
            @(posedge clk);
            #1;
            checks++;
            if (a_ack !== 1'b0) begin errors++; $display("FAIL full_ack got=%b expected=0", a_ack); end
        end
        checks++;
        if (wr_count !== w0) begin errors++; $display("FAIL busy_writes got=%0d expected=%0d", wr_count, w0); end
        syn_busy = 1'b0;
        send(0, 2'b01, 8'h99, 1);
        wait_drain();
    endtask

    task automatic test_flush();
        apply_reset();
        syn_busy = 1'b1;
        for (int i = 0; i < 4; i++) send(0, 2'b01, 8'(8'h40 + i), 1);
        send(0, 2'b00, 8'h44, 1);
        checks++;
        if (level !== 4'd5) begin errors++; $display("FAIL pre_flush_level got=%0d expected=5", level); end
        b_req = 1'b1; b_addr = 2'b11; b_din = 8'h77;
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if (b_ack !== 1'b0) begin errors++; $display("FAIL locked_b_ack got=%b expected=0", b_ack); end
        end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        checks += 3;
        if (level !== 4'd0) begin errors++; $display("FAIL flush_level got=%0d expected=0", level); end
        if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b expected=1", empty); end
        if (b_ack !== 1'b0) begin errors++; $display("FAIL flush_b_ack got=%b expected=0", b_ack); end
        exp_q.push_back({2'b11, 8'h77});
        syn_busy = 1'b0;
        send(1, 2'b11, 8'h77, 1);
        wait_drain();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send(0, 2'b01, 8'hC3, 1);
        @(posedge clk);
        #1;
        checks++;
        if (syn_write !== 1'b1) begin errors++; $display("FAIL strobe_before_rst got=%b expected=1", syn_write); end
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (syn_write !== 1'b0) begin errors++; $display("FAIL mid_rst_syn_write got=%b expected=0", syn_write); end
        if (empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty got=%b expected=1", empty); end
        if (a_ack !== 1'b0) begin errors++; $display("FAIL mid_rst_a_ack got=%b expected=0", a_ack); end
        if (b_ack !== 1'b0) begin errors++; $display("FAIL mid_rst_b_ack got=%b expected=0", b_ack); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.push_back({2'b01, 8'h3C});
        send(0, 2'b01, 8'h3C, 1);
        wait_drain();
    endtask

    initial begin
        fork monitor(); join_none
        test_reset();
        test_single();
        test_lock();
        test_round_robin();
        test_full();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
